l2_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one L2_cache request port between two L1 requesters: port 0 (instruction-side L1) and port 1 (data-side L1).
- Serialises requests and holds address, data and command stable for the whole L2 transaction.
- Masks the L2 command in the L2 ready cycle so no spurious second access is started.
- Routes the response block, hit and ready back to the granted requester; flags transactions that exceed a timeout.

---
 rtl/l2_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the instruction-side
// (port 0) and data-side (port 1) L1 caches, with per-transaction timeout.
module l2_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int BLOCK_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int BW            = BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [BW-1:0]         p0_wdata,
  input  logic                  p0_read,
  input  logic                  p0_write,
  output logic [BW-1:0]         p0_rdata,
  output logic                  p0_ready,
  output logic                  p0_hit,
  output logic                  p0_error,

  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [BW-1:0]         p1_wdata,
  input  logic                  p1_read,
  input  logic                  p1_write,
  output logic [BW-1:0]         p1_rdata,
  output logic                  p1_ready,
  output logic                  p1_hit,
  output logic                  p1_error,

  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic [BW-1:0]         l2_wdata,
  output logic                  l2_read,
  output logic                  l2_write,
  input  logic [BW-1:0]         l2_rdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,

  output logic                  grant,
  output logic                  busy,
  output logic                  timeout_sticky,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester holds pN_read/pN_write (level) until it sees the
  // one-cycle pN_ready pulse and drops the request on the following edge; the
  // L2 side sees a level command that is masked in its ready cycle.

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [TW-1:0]         timer;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         wdata_q;
  logic                  op_rd_q;
  logic                  op_wr_q;

  logic                  req0;
  logic                  req1;
  logic                  pick;
  logic                  cap_en;
  logic                  cap_hit;
  logic                  cap_err;
  logic [BW-1:0]         cap_data;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

  // Under contention the port that did not win last time is chosen.
  assign pick = (req0 & req1) ? ~last_grant : req1;

  always_comb begin
    cap_en   = 1'b0;
    cap_hit  = 1'b0;
    cap_err  = 1'b0;
    cap_data = '0;
    if (state == S_WAIT) begin
      if (l2_ready) begin
        cap_en   = 1'b1;
        cap_hit  = l2_hit;
        cap_data = l2_rdata;
      end else if (timer == TIMER_LAST) begin
        cap_en  = 1'b1;
        cap_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      last_grant     <= 1'b1;
      grant          <= 1'b0;
      timer          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      op_rd_q        <= 1'b0;
      op_wr_q        <= 1'b0;
      timeout_sticky <= 1'b0;
      p0_rdata       <= '0;
      p0_ready       <= 1'b0;
      p0_hit         <= 1'b0;
      p0_error       <= 1'b0;
      p1_rdata       <= '0;
      p1_ready       <= 1'b0;
      p1_hit         <= 1'b0;
      p1_error       <= 1'b0;
    end else begin
      p0_ready <= 1'b0;
      p0_hit   <= 1'b0;
      p0_error <= 1'b0;
      p1_ready <= 1'b0;
      p1_hit   <= 1'b0;
      p1_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 | req1) begin
            grant   <= pick;
            addr_q  <= pick ? p1_addr  : p0_addr;
            wdata_q <= pick ? p1_wdata : p0_wdata;
            // Write takes priority when a port raises both commands.
            op_wr_q <= pick ? p1_write : p0_write;
            op_rd_q <= pick ? (p1_read & ~p1_write) : (p0_read & ~p0_write);
            timer   <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timer != TIMER_MAX) begin
            timer <= timer + TW'(1);
          end
          if (cap_en) begin
            state <= S_RESP;
            if (cap_err) begin
              timeout_sticky <= 1'b1;
            end
            if (grant) begin
              p1_ready <= 1'b1;
              p1_hit   <= cap_hit;
              p1_error <= cap_err;
              p1_rdata <= cap_data;
            end else begin
              p0_ready <= 1'b1;
              p0_hit   <= cap_hit;
              p0_error <= cap_err;
              p0_rdata <= cap_data;
            end
          end
        end
        S_RESP: begin
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // The command is dropped combinationally in the L2 ready cycle so the cache
  // does not start a second access before the arbiter leaves WAIT.
  assign l2_read   = (state == S_WAIT) & op_rd_q & ~l2_ready;
  assign l2_write  = (state == S_WAIT) & op_wr_q & ~l2_ready;
  assign l2_addr   = addr_q;
  assign l2_wdata  = wdata_q;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: vector table of single transactions plus
// hand-written sequences for contention, timeout and mid-transaction reset.
module tb_l2_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BS = 4;
  localparam int TO = 8;
  localparam int BW = BS * DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] p0_addr, p1_addr, l2_addr;
  logic [BW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, l2_wdata, l2_rdata;
  logic p0_read, p0_write, p0_ready, p0_hit, p0_error;
  logic p1_read, p1_write, p1_ready, p1_hit, p1_error;
  logic l2_read, l2_write, l2_ready, l2_hit;
  logic grant, busy, timeout_sticky;
  logic [1:0] dbg_state;

  l2_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read(p0_read), .p0_write(p0_write),
    .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_hit(p0_hit), .p0_error(p0_error),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read(p1_read), .p1_write(p1_write),
    .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_hit(p1_hit), .p1_error(p1_error),
    .l2_addr(l2_addr), .l2_wdata(l2_wdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit),
    .grant(grant), .busy(busy), .timeout_sticky(timeout_sticky), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [BW+1:0] exp_q[$];   // {hit, error, rdata} per expected response
  logic [BW-1:0] last_rd0 = '0;
  logic [BW-1:0] last_rd1 = '0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, BW'(act), BW'(exp));
  endtask

  // Never both commands towards L2 in the same cycle.
  always @(negedge clk) begin
    if (rst_n && busy) begin
      n_cmp++;
      if (l2_read && l2_write) begin
        n_fail++;
        $display("FAIL l2_cmd_exclusive: got rd=%0b wr=%0b expected not both", l2_read, l2_write);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_reqs();
    p0_read = 1'b0; p0_write = 1'b0; p1_read = 1'b0; p1_write = 1'b0;
  endtask

  // Runs one transaction whose requests are already driven; lat = WAIT cycle
  // in which L2 answers (0 = never, so the timeout must fire).
  task automatic run_txn(input string tag, input logic port, input logic wr,
                         input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                         input int lat, input logic hit, input logic [BW-1:0] rd,
                         input logic exp_err);
    int n;
    int wcnt;
    int exp_wait;
    logic got;
    logic [BW+1:0] e;
    logic [BW-1:0] exp_rd;
    exp_rd   = exp_err ? '0 : rd;
    exp_wait = (lat != 0) ? lat : TO;
    exp_q.push_back({exp_err ? 1'b0 : hit, exp_err, exp_rd});

    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 8);
    check1({tag, ".busy"}, busy, 1'b1);
    check1({tag, ".grant"}, grant, port);
    check({tag, ".l2_addr"}, BW'(l2_addr), BW'(addr));
    check1({tag, ".l2_write"}, l2_write, wr);
    check1({tag, ".l2_read"}, l2_read, ~wr);
    if (wr) check({tag, ".l2_wdata"}, l2_wdata, wd);
    // Inputs changing after grant must not reach L2.
    if (port) begin p1_addr = ~addr; p1_wdata = ~wd; end
    else      begin p0_addr = ~addr; p0_wdata = ~wd; end

    wcnt = 1;
    got  = 1'b0;
    while (!got && wcnt < 40) begin
      if (wcnt == exp_wait) begin
        if (lat != 0) begin
          l2_ready = 1'b1; l2_rdata = rd; l2_hit = hit;
          #1;
          check1({tag, ".l2_cmd_masked"}, l2_read | l2_write, 1'b0);
        end
        check({tag, ".latched_addr"}, BW'(l2_addr), BW'(addr));
        check({tag, ".latched_wdata"}, l2_wdata, wd);
      end
      @(negedge clk);
      l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
      if (p0_ready || p1_ready) got = 1'b1;
      else wcnt++;
    end

    e = exp_q.pop_front();
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s.ready_timeout: got no ready expected ready after %0d waits", tag, exp_wait);
    end else begin
      check({tag, ".wait_cycles"}, BW'(wcnt), BW'(exp_wait));
      check({tag, ".ready_vec"}, BW'({p1_ready, p0_ready}), port ? BW'(2'b10) : BW'(2'b01));
      check1({tag, ".hit"}, port ? p1_hit : p0_hit, e[BW+1]);
      check1({tag, ".error"}, port ? p1_error : p0_error, e[BW]);
      check({tag, ".rdata"}, port ? p1_rdata : p0_rdata, e[BW-1:0]);
      check({tag, ".other_port"}, BW'(port ? {p0_hit, p0_error} : {p1_hit, p1_error}), '0);
      if (port) last_rd1 = e[BW-1:0]; else last_rd0 = e[BW-1:0];
    end
    // Winner drops its request; a losing requester keeps asserting.
    if (port) begin p1_read = 1'b0; p1_write = 1'b0; end
    else      begin p0_read = 1'b0; p0_write = 1'b0; end
    @(negedge clk);
    check({tag, ".post_ready"}, BW'({p1_ready, p0_ready}), '0);
    check1({tag, ".post_busy"}, busy, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]    op0;     // {write, read}
    logic [1:0]    op1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [BW-1:0] wd0;
    logic [BW-1:0] wd1;
    int            lat;
    logic          hit;
    logic [BW-1:0] rd;
    logic          exp_port;
    logic          exp_wr;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic sticky_exp;
    logic any_ready;
    vecs[0] = '{op0:2'b01, op1:2'b00, addr0:11'h040, addr1:11'h000, wd0:{BS{32'h0}}, wd1:{BS{32'h0}},
                lat:3, hit:1'b1, rd:{BS{32'hA0A0_0001}}, exp_port:1'b0, exp_wr:1'b0, exp_err:1'b0};
    vecs[1] = '{op0:2'b00, op1:2'b11, addr0:11'h000, addr1:11'h155, wd0:{BS{32'h0}}, wd1:{BS{32'h1111_2222}},
                lat:1, hit:1'b0, rd:{BS{32'hB0B0_0002}}, exp_port:1'b1, exp_wr:1'b1, exp_err:1'b0};
    vecs[2] = '{op0:2'b01, op1:2'b10, addr0:11'h020, addr1:11'h7E0, wd0:{BS{32'h0}}, wd1:{BS{32'hCAFE_0003}},
                lat:2, hit:1'b1, rd:{BS{32'hC0C0_0003}}, exp_port:1'b0, exp_wr:1'b0, exp_err:1'b0};
    vecs[3] = '{op0:2'b10, op1:2'b01, addr0:11'h011, addr1:11'h3FF, wd0:{BS{32'hDEAD_0004}}, wd1:{BS{32'h0}},
                lat:1, hit:1'b0, rd:{BS{32'hD0D0_0004}}, exp_port:1'b1, exp_wr:1'b0, exp_err:1'b0};
    vecs[4] = '{op0:2'b01, op1:2'b00, addr0:11'h100, addr1:11'h000, wd0:{BS{32'h0}}, wd1:{BS{32'h0}},
                lat:TO, hit:1'b1, rd:{BS{32'hE0E0_0005}}, exp_port:1'b0, exp_wr:1'b0, exp_err:1'b0};
    vecs[5] = '{op0:2'b00, op1:2'b01, addr0:11'h000, addr1:11'h200, wd0:{BS{32'h0}}, wd1:{BS{32'h0}},
                lat:0, hit:1'b1, rd:{BS{32'hF0F0_0006}}, exp_port:1'b1, exp_wr:1'b0, exp_err:1'b1};
    vecs[6] = '{op0:2'b00, op1:2'b10, addr0:11'h000, addr1:11'h0AA, wd0:{BS{32'h0}}, wd1:{BS{32'h3333_4444}},
                lat:5, hit:1'b1, rd:{BS{32'h1234_0007}}, exp_port:1'b1, exp_wr:1'b1, exp_err:1'b0};

    rst_n = 1'b0;
    clear_reqs();
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;

    // Reset state
    @(negedge clk);
    check1("rst.busy", busy, 1'b0);
    check1("rst.grant", grant, 1'b0);
    check("rst.outs", BW'({p0_ready, p1_ready, p0_hit, p1_hit, p0_error, p1_error,
                          l2_read, l2_write, timeout_sticky}), '0);
    check("rst.l2_addr", BW'(l2_addr), '0);
    check("rst.p0_rdata", p0_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single transactions
    sticky_exp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      p0_read = vecs[i].op0[0]; p0_write = vecs[i].op0[1];
      p1_read = vecs[i].op1[0]; p1_write = vecs[i].op1[1];
      p0_addr = vecs[i].addr0;  p1_addr = vecs[i].addr1;
      p0_wdata = vecs[i].wd0;   p1_wdata = vecs[i].wd1;
      run_txn($sformatf("vec%0d", i), vecs[i].exp_port, vecs[i].exp_wr,
              vecs[i].exp_port ? vecs[i].addr1 : vecs[i].addr0,
              vecs[i].exp_port ? vecs[i].wd1 : vecs[i].wd0,
              vecs[i].lat, vecs[i].hit, vecs[i].rd, vecs[i].exp_err);
      clear_reqs();
      sticky_exp = sticky_exp | vecs[i].exp_err;
      check1($sformatf("vec%0d.sticky", i), timeout_sticky, sticky_exp);
    end

    // l2_ready outside WAIT is ignored and captured data is held
    l2_ready = 1'b1; l2_hit = 1'b1; l2_rdata = {BS{32'h5555_AAAA}};
    @(negedge clk);
    l2_ready = 1'b0; l2_hit = 1'b0; l2_rdata = '0;
    check("idle_ready.ready", BW'({p1_ready, p0_ready, p1_hit, p0_hit}), '0);
    check1("idle_ready.busy", busy, 1'b0);
    check("idle_ready.p0_hold", p0_rdata, last_rd0);
    check("idle_ready.p1_hold", p1_rdata, last_rd1);

    // Reset in the middle of WAIT
    p0_read = 1'b1; p0_addr = 11'h123;
    @(negedge clk);
    @(negedge clk);
    check1("mid_rst.pre_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    #1;
    check1("mid_rst.busy", busy, 1'b0);
    check("mid_rst.outs", BW'({p0_ready, p1_ready, p0_hit, p0_error, l2_read, l2_write,
                              timeout_sticky, grant}), '0);
    check("mid_rst.p0_rdata", p0_rdata, '0);
    check("mid_rst.p1_rdata", p1_rdata, '0);
    check("mid_rst.l2_addr", BW'(l2_addr), '0);
    @(negedge clk);
    rst_n = 1'b1;
    any_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      any_ready = any_ready | p0_ready | p1_ready | busy;
    end
    check1("mid_rst.no_ready", any_ready, 1'b0);

    // Contention after reset: p0 first, p1 keeps requesting and is served next,
    // then a second pair alternates the same way.
    for (int r = 0; r < 2; r++) begin
      p0_read = 1'b1; p0_addr = 11'h020; p0_wdata = '0;
      p1_write = 1'b1; p1_addr = 11'h7E0; p1_wdata = {BS{32'h7E0F_0000 + r}};
      run_txn($sformatf("pair%0d.p0", r), 1'b0, 1'b0, 11'h020, '0, 3, 1'b1,
              {BS{32'h2020_0000 + r}}, 1'b0);
      run_txn($sformatf("pair%0d.p1", r), 1'b1, 1'b1, 11'h7E0, {BS{32'h7E0F_0000 + r}}, 2, 1'b0,
              {BS{32'h7E07_0000 + r}}, 1'b0);
      clear_reqs();
    end
    check1("final.sticky_clear", timeout_sticky, 1'b0);
    check("final.exp_q_empty", BW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
